cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Sequencing FSM for one direct-mapped cache: accepts CPU read/write requests, drives the set/tag
//  metadata array (valid/dirty/tag) and the data-array write enables, and runs dirty write-back and
//  line fill against the next memory level. Sits between CPU port, metadata/data arrays and memory.
// PARAMETERS
//  NUM_SETS     4   number of cache sets (must equal 2**SET_SIZE)
//  SET_SIZE     2   set-index width
//  TAG_SIZE     30  tag width; address width ADDR_W = TAG_SIZE+SET_SIZE+OFFSET_SIZE
//  OFFSET_SIZE  0   block-offset width; offset bits are passed through but never used for lookup
//  READ_ONLY    0   1: no dirty state, no write-back; cpu_req_we is ignored (treated as read)
// PORTS
//  clk                       in   1        clock, all state on rising edge
//  reset                     in   1        asynchronous, active-high
//  cpu_req_valid             in   1        CPU request present
//  cpu_req_ready             out  1        controller can accept (IDLE only)
//  cpu_req_we                in   1        1 = write, 0 = read
//  cpu_req_addr              in   ADDR_W   request address {tag,set,offset}
//  cpu_resp_valid            out  1        one-cycle completion pulse
//  cpu_resp_hit              out  1        qualifies cpu_resp_valid: 1 = original lookup hit
//  set                       out  SET_SIZE set index to metadata/data arrays (from captured addr)
//  tag                       out  TAG_SIZE tag to metadata array (from captured addr)
//  valid_block_match         in   1        metadata: selected set valid and tag equal
//  valid_dirty_bit           in   1        metadata: selected set valid and dirty
//  selected_tag              in   TAG_SIZE metadata: tag currently stored in selected set
//  clear_selected_valid_bit  out  1        metadata strobe
//  finish_new_line_install   out  1        metadata strobe: set valid, write tag
//  clear_selected_dirty_bit  out  1        metadata strobe
//  set_selected_dirty_bit    out  1        metadata strobe
//  data_we                   out  1        data array: write CPU data into selected set
//  fill_we                   out  1        data array: write mem read data into selected set
//  mem_req                   out  1        memory request, held until mem_ack
//  mem_we                    out  1        1 = write-back, 0 = fill read
//  mem_addr                  out  ADDR_W   {tag,set,OFFSET_SIZE'0}
//  mem_ack                   in   1        one-cycle completion from memory
//  hit_count, miss_count     out  32 each  saturating performance counters
// BEHAVIOUR
//  - Reset (async): state IDLE, captured addr/we cleared, miss_seen=0, counters=0; every output 0
//    except cpu_req_ready=1. Reset mid-transaction abandons it; mem_req drops immediately.
//  - States: IDLE, LOOKUP, WRITEBACK, FILL, INSTALL. All strobes are Moore/Mealy combinational,
//    asserted one cycle only, and mutually exclusive except install+set_dirty in INSTALL.
//  - IDLE: ready=1; valid&ready captures addr/we, miss_seen<=0 -> LOOKUP. Else stay.
//  - LOOKUP (metadata is combinational, result same cycle):
//    hit: cpu_resp_valid=1, cpu_resp_hit=!miss_seen; if we: data_we=1, set_selected_dirty_bit=1;
//         hit_count++ only when !miss_seen -> IDLE.
//    miss: miss_seen<=1, miss_count++; valid_dirty_bit & !READ_ONLY -> WRITEBACK, else -> FILL.
//  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={selected_tag,set,0}. On mem_ack:
//    clear_selected_dirty_bit=1 -> FILL.
//  - FILL: mem_req=1, mem_we=0, mem_addr={tag,set,0}. On mem_ack: fill_we=1 -> INSTALL.
//  - INSTALL: finish_new_line_install=1 -> LOOKUP (re-lookup now hits; write handled there).
//  - Hit latency 2 cycles accept->resp. Clean miss 4 + memory latency; dirty miss adds one
//    more memory round trip.
//  - mem_req/mem_we/mem_addr stable from assertion until the mem_ack cycle inclusive.
//  - mem_ack outside WRITEBACK/FILL is ignored. cpu_req_valid while busy is not accepted.
//  - Counters saturate at 32'hFFFF_FFFF (no wrap). set/tag outputs are registered captures,
//    stable for the whole transaction.
//  - READ_ONLY=1: dirty strobes and data_we tied 0; WRITEBACK unreachable.
// STRUCTURE
//  - cache_pkg: cache_state_e enum {IDLE,LOOKUP,WRITEBACK,FILL,INSTALL}; addr split helper
//    function; counter width localparam.
//  - One sub-module: sat_counter (WIDTH param, inc, async reset), instantiated twice.
// TESTING (NUM_SETS=4, defaults; memory model acks after 3 cycles)
//  - Read addr 0x10 after reset -> miss, FILL addr 0x10, install, resp_hit=0; repeat -> resp 2
//    cycles after accept, resp_hit=1; hit_count=1, miss_count=1.
//  - Write 0x10 hit -> data_we & set_dirty pulse; then read 0x14 (set 0, other tag) ->
//    WRITEBACK mem_addr=0x10, clear_dirty on ack, then FILL mem_addr=0x14.
//  - Hold mem_ack low 20 cycles in FILL -> mem_req/mem_addr stable, ready=0, no strobes.
//  - Assert reset in WRITEBACK -> mem_req=0 same cycle, state IDLE, counters 0, ready=1.
//  - Force miss_count to 32'hFFFF_FFFF then miss -> stays saturated; READ_ONLY=1 write
//    request -> no dirty strobe, no WRITEBACK.

Source files
------------

// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module : cache_pkg
// Brief  : Shared types and helpers for the direct-mapped cache controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

    localparam int unsigned c_COUNTER_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        INSTALL   = 3'd4
    } cache_state_e;

    // Extracts a bit field of an address; callers cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_controller_sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
//------------------------------------------------------------------------------
// Module : cache_controller
// Brief  : Request sequencer for a direct-mapped cache: lookup, write-back, fill.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_controller
    import cache_pkg::*;
#(
    parameter  int NUM_SETS    = 4,
    parameter  int SET_SIZE    = 2,
    parameter  int TAG_SIZE    = 30,
    parameter  int OFFSET_SIZE = 0,
    parameter  int READ_ONLY   = 0,
    localparam int ADDR_W      = TAG_SIZE + SET_SIZE + OFFSET_SIZE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_req_valid,
    output logic                       cpu_req_ready,
    input  logic                       cpu_req_we,
    input  logic [ADDR_W-1:0]          cpu_req_addr,
    output logic                       cpu_resp_valid,
    output logic                       cpu_resp_hit,
    output logic [SET_SIZE-1:0]        set,
    output logic [TAG_SIZE-1:0]        tag,
    input  logic                       valid_block_match,
    input  logic                       valid_dirty_bit,
    input  logic [TAG_SIZE-1:0]        selected_tag,
    output logic                       clear_selected_valid_bit,
    output logic                       finish_new_line_install,
    output logic                       clear_selected_dirty_bit,
    output logic                       set_selected_dirty_bit,
    output logic                       data_we,
    output logic                       fill_we,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    output logic [c_COUNTER_WIDTH-1:0] hit_count,
    output logic [c_COUNTER_WIDTH-1:0] miss_count
);

    localparam bit c_RO          = (READ_ONLY != 0);
    localparam bit c_GEOMETRY_OK = (NUM_SETS == (1 << SET_SIZE));

    generate
        if (!c_GEOMETRY_OK) begin : g_bad_geometry
            $error("cache_controller: NUM_SETS must equal 2**SET_SIZE");
        end
    endgenerate

    cache_state_e        r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_miss_seen;
    logic [TAG_SIZE-1:0] w_mem_tag;
    logic [ADDR_W-1:0]   w_mem_base;
    logic                w_hit_inc;
    logic                w_miss_inc;

    assign set = SET_SIZE'(addr_field(64'(r_addr), OFFSET_SIZE, SET_SIZE));
    assign tag = TAG_SIZE'(addr_field(64'(r_addr), OFFSET_SIZE + SET_SIZE, TAG_SIZE));

    // Line address: offset bits forced to zero, tag chosen by state.
    assign w_mem_base = ADDR_W'({w_mem_tag, set});
    assign mem_addr   = w_mem_base << OFFSET_SIZE;

    // Lines are overwritten in place by the install, so explicit invalidation is never needed.
    assign clear_selected_valid_bit = 1'b0;

    assign w_hit_inc  = (r_state == LOOKUP) && valid_block_match && !r_miss_seen;
    assign w_miss_inc = (r_state == LOOKUP) && !valid_block_match;

    always_comb begin
        cpu_req_ready            = (r_state == IDLE);
        cpu_resp_valid           = 1'b0;
        cpu_resp_hit             = 1'b0;
        finish_new_line_install  = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        data_we                  = 1'b0;
        fill_we                  = 1'b0;
        mem_req                  = 1'b0;
        mem_we                   = 1'b0;
        w_mem_tag                = tag;
        case (r_state)
            LOOKUP: begin
                if (valid_block_match) begin
                    cpu_resp_valid         = 1'b1;
                    cpu_resp_hit           = !r_miss_seen;
                    data_we                = r_we;
                    set_selected_dirty_bit = r_we;
                end
            end
            WRITEBACK: begin
                mem_req                  = 1'b1;
                mem_we                   = 1'b1;
                w_mem_tag                = selected_tag;
                clear_selected_dirty_bit = mem_ack && !c_RO;
            end
            FILL: begin
                mem_req = 1'b1;
                fill_we = mem_ack;
            end
            INSTALL: begin
                finish_new_line_install = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_miss_seen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        r_addr      <= cpu_req_addr;
                        r_we        <= cpu_req_we && !c_RO;
                        r_miss_seen <= 1'b0;
                        r_state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (valid_block_match) begin
                        r_state <= IDLE;
                    end else begin
                        r_miss_seen <= 1'b1;
                        r_state     <= (valid_dirty_bit && !c_RO) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: if (mem_ack) r_state <= FILL;
                FILL:      if (mem_ack) r_state <= INSTALL;
                // The re-lookup after install hits and completes any pending write.
                INSTALL:   r_state <= LOOKUP;
                default:   r_state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(c_COUNTER_WIDTH)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(c_COUNTER_WIDTH)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
//------------------------------------------------------------------------------
// Module : tb_cache_controller
// Brief  : Directed bench for cache_controller with metadata and memory models.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic        cpu_resp_valid, cpu_resp_hit;
    logic [1:0]  set;
    logic [29:0] tag;
    logic        valid_block_match, valid_dirty_bit;
    logic [29:0] selected_tag;
    logic        clear_valid, finish_install, clear_dirty, set_dirty;
    logic        data_we, fill_we, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, hit_count, miss_count;

    logic        ro_valid, ro_ready, ro_we;
    logic [31:0] ro_addr;
    logic        ro_resp_valid, ro_resp_hit;
    logic [1:0]  ro_set;
    logic [29:0] ro_tag;
    logic        ro_match, ro_dirty;
    logic        ro_clear_valid, ro_finish, ro_clear_dirty, ro_set_dirty;
    logic        ro_data_we, ro_fill_we, ro_mem_req, ro_mem_we, ro_ack;
    logic [31:0] ro_mem_addr, ro_hit_count, ro_miss_count;

    logic        sat_inc;
    logic [2:0]  sat_count;

    int checks = 0;
    int errors = 0;

    cache_controller dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
        .set(set), .tag(tag),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
        .selected_tag(selected_tag),
        .clear_selected_valid_bit(clear_valid), .finish_new_line_install(finish_install),
        .clear_selected_dirty_bit(clear_dirty), .set_selected_dirty_bit(set_dirty),
        .data_we(data_we), .fill_we(fill_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.READ_ONLY(1)) dut_ro (
        .clk(clk), .reset(reset),
        .cpu_req_valid(ro_valid), .cpu_req_ready(ro_ready),
        .cpu_req_we(ro_we), .cpu_req_addr(ro_addr),
        .cpu_resp_valid(ro_resp_valid), .cpu_resp_hit(ro_resp_hit),
        .set(ro_set), .tag(ro_tag),
        .valid_block_match(ro_match), .valid_dirty_bit(ro_dirty),
        .selected_tag(30'h3),
        .clear_selected_valid_bit(ro_clear_valid), .finish_new_line_install(ro_finish),
        .clear_selected_dirty_bit(ro_clear_dirty), .set_selected_dirty_bit(ro_set_dirty),
        .data_we(ro_data_we), .fill_we(ro_fill_we),
        .mem_req(ro_mem_req), .mem_we(ro_mem_we), .mem_addr(ro_mem_addr), .mem_ack(ro_ack),
        .hit_count(ro_hit_count), .miss_count(ro_miss_count)
    );

    sat_counter #(.WIDTH(3)) u_sat (.clk(clk), .reset(reset), .inc(sat_inc), .count(sat_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Metadata array model driven by the controller's strobes.
    logic        m_valid [0:3];
    logic        m_dirty [0:3];
    logic [29:0] m_tag   [0:3];

    assign valid_block_match = m_valid[set] && (m_tag[set] == tag);
    assign valid_dirty_bit   = m_valid[set] && m_dirty[set];
    assign selected_tag      = m_tag[set];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] <= 1'b0;
                m_dirty[i] <= 1'b0;
                m_tag[i]   <= '0;
            end
        end else begin
            if (finish_install) begin
                m_valid[set] <= 1'b1;
                m_dirty[set] <= 1'b0;
                m_tag[set]   <= tag;
            end
            if (set_dirty)   m_dirty[set] <= 1'b1;
            if (clear_dirty) m_dirty[set] <= 1'b0;
            if (clear_valid) m_valid[set] <= 1'b0;
        end
    end

    // Memory model: ack pulse on the fourth cycle of a request unless held off.
    logic model_ack, hold_ack, stray_ack;
    int   mem_cnt;
    assign mem_ack = model_ack | stray_ack;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_ack <= 1'b0;
            mem_cnt   <= 0;
        end else if (model_ack) begin
            model_ack <= 1'b0;
            mem_cnt   <= 0;
        end else if (mem_req && !hold_ack) begin
            if (mem_cnt == 2) model_ack <= 1'b1;
            else              mem_cnt   <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    // Presents one request and returns at the falling edge of the LOOKUP cycle.
    task automatic issue(input logic [31:0] addr, input logic we);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        cpu_req_we    = we;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Walks a miss from the LOOKUP cycle to the final response.
    task automatic do_miss(input string name, input bit wb, input logic [31:0] wb_addr,
                           input logic [31:0] fill_addr);
        bit ok;
        checks++;
        if (cpu_resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL %s_lookup: resp_valid=%b mem_req=%b required 0/0", name, cpu_resp_valid, mem_req);
        end
        @(negedge clk);
        if (wb) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wb_addr) begin
                errors++; $display("FAIL %s_wb_req: req=%b we=%b addr=%h required 1/1/%h", name, mem_req, mem_we, mem_addr, wb_addr);
            end
            wait_ack(ok);
            checks++;
            if (!ok || clear_dirty !== 1'b1 || fill_we !== 1'b0) begin
                errors++; $display("FAIL %s_wb_ack: ack_seen=%b clear_dirty=%b fill_we=%b required 1/1/0", name, ok, clear_dirty, fill_we);
            end
            @(negedge clk);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== fill_addr) begin
            errors++; $display("FAIL %s_fill_req: req=%b we=%b addr=%h required 1/0/%h", name, mem_req, mem_we, mem_addr, fill_addr);
        end
        wait_ack(ok);
        checks++;
        if (!ok || fill_we !== 1'b1 || clear_dirty !== 1'b0) begin
            errors++; $display("FAIL %s_fill_ack: ack_seen=%b fill_we=%b clear_dirty=%b required 1/1/0", name, ok, fill_we, clear_dirty);
        end
        @(negedge clk);
        checks++;
        if (finish_install !== 1'b1 || mem_req !== 1'b0 || fill_we !== 1'b0) begin
            errors++; $display("FAIL %s_install: finish=%b mem_req=%b fill_we=%b required 1/0/0", name, finish_install, mem_req, fill_we);
        end
        @(negedge clk);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_hit !== 1'b0) begin
            errors++; $display("FAIL %s_resp: valid=%b hit=%b required 1/0", name, cpu_resp_valid, cpu_resp_hit);
        end
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL %s_idle: ready=%b required 1", name, cpu_req_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || mem_req !== 1'b0 ||
            hit_count !== 32'd0 || miss_count !== 32'd0 || set !== 2'd0 || tag !== 30'd0) begin
            errors++; $display("FAIL reset_state: ready=%b resp=%b req=%b hits=%0d misses=%0d set=%0d tag=%h required 1/0/0/0/0/0/0",
                               cpu_req_ready, cpu_resp_valid, mem_req, hit_count, miss_count, set, tag);
        end
        checks++;
        if ({clear_valid, finish_install, clear_dirty, set_dirty, data_we, fill_we, mem_we} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes: got %b required 0000000",
                               {clear_valid, finish_install, clear_dirty, set_dirty, data_we, fill_we, mem_we});
        end
    endtask

    task automatic test_read_miss();
        issue(32'h10, 1'b0);
        do_miss("read_miss", 1'b0, 32'h0, 32'h10);
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd1) begin
            errors++; $display("FAIL read_miss_counts: hits=%0d misses=%0d required 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_read_hit();
        issue(32'h10, 1'b0);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_hit !== 1'b1 || data_we !== 1'b0 || set_dirty !== 1'b0) begin
            errors++; $display("FAIL read_hit_resp: valid=%b hit=%b data_we=%b set_dirty=%b required 1/1/0/0",
                               cpu_resp_valid, cpu_resp_hit, data_we, set_dirty);
        end
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1 || hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++; $display("FAIL read_hit_counts: ready=%b hits=%0d misses=%0d required 1/1/1", cpu_req_ready, hit_count, miss_count);
        end
    endtask

    task automatic test_write_hit();
        issue(32'h10, 1'b1);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_hit !== 1'b1 || data_we !== 1'b1 || set_dirty !== 1'b1) begin
            errors++; $display("FAIL write_hit_resp: valid=%b hit=%b data_we=%b set_dirty=%b required 1/1/1/1",
                               cpu_resp_valid, cpu_resp_hit, data_we, set_dirty);
        end
        @(negedge clk);
        checks++;
        if (data_we !== 1'b0 || set_dirty !== 1'b0 || cpu_resp_valid !== 1'b0 || hit_count !== 32'd2) begin
            errors++; $display("FAIL write_hit_after: data_we=%b set_dirty=%b resp=%b hits=%0d required 0/0/0/2",
                               data_we, set_dirty, cpu_resp_valid, hit_count);
        end
    endtask

    task automatic test_dirty_miss();
        issue(32'h14, 1'b0);
        do_miss("dirty_miss", 1'b1, 32'h10, 32'h14);
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd2) begin
            errors++; $display("FAIL dirty_miss_counts: hits=%0d misses=%0d required 2/2", hit_count, miss_count);
        end
    endtask

    task automatic test_stall();
        bit ok;
        hold_ack = 1'b1;
        issue(32'h18, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h18 || cpu_req_ready !== 1'b0 ||
                cpu_resp_valid !== 1'b0 || {finish_install, clear_dirty, set_dirty, data_we, fill_we} !== 5'b0) begin
                errors++; $display("FAIL stall_cycle%0d: req=%b we=%b addr=%h ready=%b resp=%b strobes=%b required 1/0/00000018/0/0/00000",
                                   i, mem_req, mem_we, mem_addr, cpu_req_ready, cpu_resp_valid,
                                   {finish_install, clear_dirty, set_dirty, data_we, fill_we});
            end
            @(negedge clk);
        end
        hold_ack = 1'b0;
        wait_ack(ok);
        checks++;
        if (!ok || fill_we !== 1'b1 || mem_addr !== 32'h18) begin
            errors++; $display("FAIL stall_release: ack_seen=%b fill_we=%b addr=%h required 1/1/00000018", ok, fill_we, mem_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1 || miss_count !== 32'd3) begin
            errors++; $display("FAIL stall_done: ready=%b misses=%0d required 1/3", cpu_req_ready, miss_count);
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        stray_ack = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || fill_we !== 1'b0 || clear_dirty !== 1'b0) begin
            errors++; $display("FAIL stray_ack_strobes: req=%b fill_we=%b clear_dirty=%b required 0/0/0", mem_req, fill_we, clear_dirty);
        end
        @(negedge clk);
        stray_ack = 1'b0;
        checks++;
        if (cpu_req_ready !== 1'b1 || finish_install !== 1'b0) begin
            errors++; $display("FAIL stray_ack_state: ready=%b finish=%b required 1/0", cpu_req_ready, finish_install);
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h18, 1'b1);
        @(negedge clk);
        issue(32'h1C, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h18) begin
            errors++; $display("FAIL reset_mid_wb: req=%b we=%b addr=%h required 1/1/00000018", mem_req, mem_we, mem_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_req_ready !== 1'b1 || hit_count !== 32'd0 || miss_count !== 32'd0 ||
            set !== 2'd0 || tag !== 30'd0) begin
            errors++; $display("FAIL reset_mid_state: req=%b ready=%b hits=%0d misses=%0d set=%0d tag=%h required 0/1/0/0/0/0",
                               mem_req, cpu_req_ready, hit_count, miss_count, set, tag);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(32'h10, 1'b0);
        do_miss("post_reset", 1'b0, 32'h0, 32'h10);
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++; $display("FAIL post_reset_counts: hits=%0d misses=%0d required 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_read_only();
        ro_match = 1'b0;
        ro_dirty = 1'b1;
        @(negedge clk);
        ro_valid = 1'b1; ro_we = 1'b1; ro_addr = 32'h20;
        @(negedge clk);
        ro_valid = 1'b0; ro_we = 1'b0;
        checks++;
        if (ro_resp_valid !== 1'b0 || ro_set_dirty !== 1'b0 || ro_mem_req !== 1'b0) begin
            errors++; $display("FAIL ro_lookup: resp=%b set_dirty=%b req=%b required 0/0/0", ro_resp_valid, ro_set_dirty, ro_mem_req);
        end
        @(negedge clk);
        checks++;
        if (ro_mem_req !== 1'b1 || ro_mem_we !== 1'b0 || ro_mem_addr !== 32'h20) begin
            errors++; $display("FAIL ro_no_writeback: req=%b we=%b addr=%h required 1/0/00000020", ro_mem_req, ro_mem_we, ro_mem_addr);
        end
        ro_ack = 1'b1;
        #1;
        checks++;
        if (ro_fill_we !== 1'b1 || ro_clear_dirty !== 1'b0) begin
            errors++; $display("FAIL ro_fill_ack: fill_we=%b clear_dirty=%b required 1/0", ro_fill_we, ro_clear_dirty);
        end
        @(negedge clk);
        ro_ack = 1'b0;
        ro_match = 1'b1;
        checks++;
        if (ro_finish !== 1'b1 || ro_set_dirty !== 1'b0) begin
            errors++; $display("FAIL ro_install: finish=%b set_dirty=%b required 1/0", ro_finish, ro_set_dirty);
        end
        @(negedge clk);
        checks++;
        if (ro_resp_valid !== 1'b1 || ro_resp_hit !== 1'b0 || ro_data_we !== 1'b0 || ro_set_dirty !== 1'b0 ||
            ro_miss_count !== 32'd1) begin
            errors++; $display("FAIL ro_resp: valid=%b hit=%b data_we=%b set_dirty=%b misses=%0d required 1/0/0/0/1",
                               ro_resp_valid, ro_resp_hit, ro_data_we, ro_set_dirty, ro_miss_count);
        end
        @(negedge clk);
        ro_match = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            sat_inc = 1'b1;
            @(negedge clk);
            sat_inc = 1'b0;
            if (i == 3 || i == 7 || i == 9) begin
                checks++;
                if (sat_count !== ((i > 7) ? 3'd7 : 3'(i))) begin
                    errors++; $display("FAIL saturate_after%0d: count=%0d required %0d", i, sat_count, (i > 7) ? 7 : i);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0;
        ro_valid = 1'b0; ro_we = 1'b0; ro_addr = '0;
        ro_match = 1'b0; ro_dirty = 1'b0; ro_ack = 1'b0;
        hold_ack = 1'b0; stray_ack = 1'b0; sat_inc = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_stall();
        test_stray_ack();
        test_reset_mid();
        test_read_only();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
